// File: rtl/handshake_responder.sv
// handshake_responder
//    Four-phase req/ack responder. A request is accepted in IDLE, the FSM
//    spends a programmable number of cycles in BUSY, then raises ack with
//    rsp_data = req_data + 1. When the initiator holds req high for too long
//    after ack, the FSM moves to ERR. It leaves ERR only once req is low
//    again, so it can never lock up.
//
// Ports
//    clk       in   rising-edge clock
//    rst_n     in   asynchronous active-low reset
//    req       in   four-phase request
//    req_data  in   request payload, sampled on acceptance
//    latency   in   BUSY cycle count, sampled on acceptance
//    ack       out  acknowledge, rsp_data valid while high
//    rsp_data  out  response payload (req_data + 1, wrapping)
//    busy      out  high while in BUSY
//    err       out  high while in ERR
//    state_o   out  state encoding: IDLE=0, BUSY=1, ACK=2, ERR=3

module handshake_responder #(
   parameter int DATA_W   = 8,
   parameter int LAT_W    = 4,
   parameter int TIMEOUT  = 16,
   parameter int ERR_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [DATA_W-1:0] req_data,
   input  logic [LAT_W-1:0]  latency,
   output logic              ack,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              err,
   output logic [1:0]        state_o
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int ERR_W = $clog2(ERR_HOLD + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t           state;
   logic [LAT_W-1:0] lat_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [ERR_W-1:0] err_cnt;

   // Single FSM register block. The Moore flags ack/busy/err are registered
   // alongside the state. Every transition loads them with the decode of the
   // state being entered, so they always agree with state_o.
   // tmo_cnt counts ACK cycles that have already completed with req high.
   // err_cnt counts completed ERR cycles and saturates at ERR_HOLD-1. Exit is
   // therefore possible at the end of the ERR_HOLD-th ERR cycle at the
   // earliest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ack      <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         rsp_data <= '0;
         lat_cnt  <= '0;
         tmo_cnt  <= '0;
         err_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  rsp_data <= req_data + DATA_W'(1);
                  lat_cnt  <= latency;
                  tmo_cnt  <= '0;
                  if (latency == '0) begin
                     state <= S_ACK;
                     ack   <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_BUSY;
                     ack   <= 1'b0;
                     busy  <= 1'b1;
                  end
                  err <= 1'b0;
               end
            end

            // An abort (req low) takes priority over completion on the last cycle.
            S_BUSY: begin
               if (!req) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (lat_cnt == LAT_W'(1)) begin
                  state   <= S_ACK;
                  busy    <= 1'b0;
                  ack     <= 1'b1;
                  tmo_cnt <= '0;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end

            S_ACK: begin
               if (!req) begin
                  state <= S_IDLE;
                  ack   <= 1'b0;
               end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  state   <= S_ERR;
                  ack     <= 1'b0;
                  err     <= 1'b1;
                  err_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end

            S_ERR: begin
               if (!req && (err_cnt >= ERR_W'(ERR_HOLD - 1))) begin
                  state <= S_IDLE;
                  err   <= 1'b0;
               end else if (err_cnt < ERR_W'(ERR_HOLD - 1)) begin
                  err_cnt <= err_cnt + ERR_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
               ack   <= 1'b0;
               busy  <= 1'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = state;

endmodule
